// File: rtl/psum_accumulator.sv
// Accumulates NUM_TERMS signed partial sums per kernel window, applies optional ReLU,
// saturates to OUT_W and hands the result downstream over a valid/ready handshake.
module psum_accumulator #(
    parameter int IN_W      = 17,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 8,
    parameter int NUM_TERMS = 9,
    parameter int RELU      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t                   state, state_next;
    logic                     ready_en;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  in_ext;
    logic signed [ACC_W-1:0]  final_sum;
    logic signed [ACC_W-1:0]  relu_val;
    logic [OUT_W-1:0]         sat_data;
    logic                     sat_flag;
    logic                     accept;
    logic                     last;

    assign in_ext    = ACC_W'($signed(in_data));
    assign final_sum = acc + in_ext;
    assign last      = (cnt == CNT_W'(NUM_TERMS - 1));

    // in_ready stays low while in reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = ready_en;
                accept   = in_valid && ready_en && !clr;
                if (accept && last) state_next = OUT;
            end
            OUT: begin
                if (out_ready) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
        if (clr) state_next = ACCUM;
    end

    always_comb begin
        relu_val = final_sum;
        if (RELU != 0 && final_sum < 0) relu_val = '0;
        sat_data = relu_val[OUT_W-1:0];
        sat_flag = 1'b0;
        if (relu_val > SAT_MAX) begin
            sat_data = SAT_MAX[OUT_W-1:0];
            sat_flag = 1'b1;
        end else if (relu_val < SAT_MIN) begin
            sat_data = SAT_MIN[OUT_W-1:0];
            sat_flag = 1'b1;
        end
    end

    // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (clr) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    out_data  <= sat_data;
                    out_sat   <= sat_flag;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= final_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
                out_sat   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench: two instances (ReLU on / ReLU off) share one stimulus stream and
// are compared against hand-computed results.
module tb_psum_accumulator;

    localparam int IN_W  = 17;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_ready = 1'b0;

    logic             in_ready_r, out_valid_r, out_sat_r;
    logic [OUT_W-1:0] out_data_r;
    logic             in_ready_p, out_valid_p, out_sat_p;
    logic [OUT_W-1:0] out_data_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psum_accumulator #(.RELU(1)) dut_relu (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_sat(out_sat_r)
    );

    psum_accumulator #(.RELU(0)) dut_pass (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_p), .in_data(in_data),
        .out_valid(out_valid_p), .out_ready(out_ready),
        .out_data(out_data_p), .out_sat(out_sat_p)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present value for n rising edges; returns #1 after the last edge.
    task automatic feed(input int value, input int n);
        in_valid = 1'b1;
        in_data  = IN_W'(value);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int data_r, input int sat_r,
                                 input int data_p, input int sat_p);
        check({tag, "_valid_r"}, out_valid_r, 1);
        check({tag, "_valid_p"}, out_valid_p, 1);
        check({tag, "_data_r"}, $signed(out_data_r), data_r);
        check({tag, "_sat_r"}, out_sat_r, sat_r);
        check({tag, "_data_p"}, $signed(out_data_p), data_p);
        check({tag, "_sat_p"}, out_sat_p, sat_p);
        check({tag, "_ready"}, in_ready_r, 0);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drained"}, out_valid_r, 0);
        check({tag, "_sat_clr"}, out_sat_r, 0);
        check({tag, "_ready_back"}, in_ready_r, 1);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", out_valid_r, 0);
        check("rst_data", $signed(out_data_r), 0);
        check("rst_sat", out_sat_r, 0);
        check("rst_ready", in_ready_r, 0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", in_ready_r, 1);

        // Basic sum, latency of exactly one cycle after the ninth accept
        feed(10, 8);
        check("lat_before", out_valid_r, 0);
        feed(10, 1);
        expect_result("sum90", 90, 0, 90, 0);
        drain("sum90");

        // Positive saturation
        feed(20, 9);
        expect_result("sum180", 127, 1, 127, 1);
        drain("sum180");

        // Large negative: relu -> 0, pass -> clamp to min without wrap
        feed(-65536, 9);
        expect_result("neg_big", 0, 0, -128, 1);
        drain("neg_big");

        // Small negative: relu clamp alone does not flag saturation
        feed(-5, 9);
        expect_result("neg45", 0, 0, -45, 0);
        drain("neg45");

        // Backpressure: output holds, no input consumed
        feed(7, 9);
        in_valid = 1'b1;
        in_data  = IN_W'(100);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", out_valid_r, 1);
            check("bp_data", $signed(out_data_r), 63);
            check("bp_ready", in_ready_r, 0);
        end
        in_valid = 1'b0;
        drain("bp");
        feed(1, 9);
        expect_result("after_bp", 9, 0, 9, 0);
        drain("after_bp");

        // clr during accumulation discards partial sum and the clr-cycle input
        feed(50, 4);
        clr = 1'b1;
        feed(50, 1);
        clr = 1'b0;
        feed(1, 9);
        expect_result("after_clr", 9, 0, 9, 0);
        drain("after_clr");

        // clr while a result is pending drops it
        feed(20, 9);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_out_valid", out_valid_r, 0);
        check("clr_out_sat", out_sat_r, 0);
        check("clr_out_ready", in_ready_r, 1);
        feed(1, 9);
        expect_result("post_clr_out", 9, 0, 9, 0);

        // Asynchronous reset with a pending result clears outputs without a clock edge
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid_r, 0);
        check("arst_data", $signed(out_data_r), 0);
        check("arst_sat", out_sat_r, 0);
        check("arst_ready", in_ready_r, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset after five accepts discards the partial sum
        feed(2, 5);
        #2 rst_n = 1'b0;
        #1;
        check("arst2_valid", out_valid_r, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        feed(2, 9);
        expect_result("after_rst", 18, 0, 18, 0);
        drain("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
